accum_seg_driver: RTL and testbench
===================================

ACCUM_SEG_DRIVER -- requirements
Module: accum_seg_driver

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits (legal 2..16).
REQ-002 SHALL have parameter DIGITS, default 3, number of display digits; SHALL be >= decimal digit count of 2^(WIDTH+1)-1; elaboration SHALL fail otherwise.
REQ-003 SHALL have parameter REFRESH_DIV, default 50000, clock cycles per digit in the scan (legal >= 2).
REQ-004 SHALL run on one clock with asynchronous active-high reset.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 start  in  1  single-cycle request to add a+b+cin.
REQ-008 a, b  in  WIDTH  unsigned operands.
REQ-009 cin  in  1  carry in.
REQ-010 busy  out  1  high from the cycle after an accepted start until done.
REQ-011 done  out  1  one-cycle pulse when display value updates.
REQ-012 sum  out  WIDTH  registered sum; cout  out  1  registered carry out.
REQ-013 seg  out  7  active-low segments, seg[6]=g ... seg[0]=a.
REQ-014 an  out  DIGITS  active-low one-hot digit enable; dp  out  1  decimal point, always 1 (off).

Function
REQ-015 start SHALL be accepted only when busy=0; start while busy=1 SHALL be ignored with no effect.
REQ-016 On the edge accepting start, {cout,sum} SHALL load a+b+cin (WIDTH+1-bit result, no truncation), state IDLE->CONVERT.
REQ-017 CONVERT SHALL perform iterative double-dabble, one bit per cycle, for exactly WIDTH+1 cycles into a DIGITS*4-bit scratch register.
REQ-018 On the final CONVERT cycle the displayed BCD register SHALL load the scratch result, done SHALL pulse for one cycle, state SHALL return to IDLE, busy SHALL drop with done.
REQ-019 Latency: start sampled at edge 0 -> done high after edge WIDTH+2 (WIDTH=8: 10 cycles); back-to-back start legal on the cycle done is high? No -- busy is low that cycle, so start SHALL be accepted then.
REQ-020 The displayed BCD register SHALL hold its previous value throughout CONVERT (no partial values shown).
REQ-021 Scan counter SHALL count 0..REFRESH_DIV-1; on wrap digit index SHALL advance, DIGITS-1 wrapping to 0; digit 0 = least significant.
REQ-022 an SHALL be ~(1<<index); seg SHALL be the encoding of the selected BCD nibble: 0=1000000,1=1111001,2=0100100,3=0110000,4=0011001,5=0010010,6=0000010,7=1111000,8=0000000,9=0010000; nibble 10..15 SHALL give blank 1111111.
REQ-023 Scanning SHALL be continuous and independent of start/busy.

Reset
REQ-024 While rst=1 (asynchronous): state IDLE, busy 0, done 0, sum 0, cout 0, displayed BCD 0, scratch 0, scan counter 0, index 0, an = ~1, seg 1000000, dp 1.
REQ-025 Reset during CONVERT SHALL abort conversion; no done pulse SHALL follow deassertion.

Configuration
REQ-026 Macro ACCUM_SEG_BLANK_LEADING_EN: when defined, digits above the most significant non-zero digit SHALL show blank 1111111 (digit 0 always shown); when undefined, all digits SHALL show their value including leading zeros.

Structure
REQ-027 Package seg_pkg SHALL hold the ten segment codes, SEG_BLANK, and the state enum (IDLE, CONVERT).
REQ-028 Sub-module bcd_to_seg (4-bit nibble -> 7-bit active-low code, combinational) SHALL be the only decoder instance.

Verification (WIDTH=8, DIGITS=3, REFRESH_DIV=4)
REQ-029 a=200,b=100,cin=1, start -> done at cycle 10, sum=45, cout=1, scan shows digits 1,0,3 (seg 1111001,1000000,0110000).
REQ-030 a=255,b=255,cin=1 -> {cout,sum}=511, digits 1,1,5; then start during busy with a=0 -> ignored, display stays 511.
REQ-031 a=7,b=0,cin=0 -> digits 7,0,0 without macro; 7,blank,blank with ACCUM_SEG_BLANK_LEADING_EN.
REQ-032 rst asserted at cycle 5 of conversion -> all REQ-024 values immediately, no done after release, display 000.
REQ-033 Idle 12 cycles -> an sequence 110,101,011 each held 4 cycles, then wraps to 110.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared definitions for the accumulator / seven-segment driver:
// active-low segment codes, the blank code and the controller state type.
package seg_pkg;

  // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic {
    IDLE    = 1'b0,
    CONVERT = 1'b1
  } state_t;

  // Number of decimal digits needed to print v.
  function automatic int dec_digits(input int unsigned v);
    int          n;
    int unsigned r;
    n = 1;
    r = v;
    for (int i = 0; i < 12; i++) begin
      if (r >= 10) begin
        r = r / 10;
        n = n + 1;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD nibble to active-low seven-segment code.
// Non-decimal nibbles (10..15) produce a blank digit.
module bcd_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (nib)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/accum_seg_driver.sv
// Adds a+b+cin on request, converts the result to BCD by double-dabble and
// scans it onto a multiplexed seven-segment display. Define
// ACCUM_SEG_BLANK_LEADING_EN to blank leading zero digits (digit 0 always shown).
module accum_seg_driver
  import seg_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DIGITS      = 3,
  parameter int REFRESH_DIV = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic              cin,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  sum,
  output logic              cout,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an,
  output logic              dp
);

  localparam int BCD_W  = DIGITS * 4;
  localparam int CNT_W  = $clog2(REFRESH_DIV);
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int STEP_W = 5;
  localparam logic [STEP_W-1:0] STEPS = STEP_W'(WIDTH + 1);

  if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
    $error("accum_seg_driver: WIDTH must be in 2..16");
  end
  if (DIGITS < dec_digits((32'd1 << (WIDTH + 1)) - 32'd1)) begin : g_bad_digits
    $error("accum_seg_driver: DIGITS too small for a WIDTH+1 bit result");
  end
  if (REFRESH_DIV < 2) begin : g_bad_refresh
    $error("accum_seg_driver: REFRESH_DIV must be at least 2");
  end

  state_t            state, state_next;
  logic              accept, finish;
  logic [WIDTH:0]    total;
  logic [WIDTH:0]    bin;
  logic [BCD_W-1:0]  scratch, scratch_adj, scratch_next;
  logic [BCD_W-1:0]  disp_bcd;
  logic [STEP_W-1:0] step_cnt;
  logic [CNT_W-1:0]  scan_cnt;
  logic [IDX_W-1:0]  digit_idx;
  logic [DIGITS-1:0] lead_blank;
  logic [3:0]        nib_sel;

  assign total = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = CONVERT;
        end
      end
      CONVERT: begin
        if (step_cnt == STEPS) begin
          finish     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == CONVERT);

  // Double-dabble step: add 3 to every digit >= 5, then shift in the next bit.
  always_comb begin
    scratch_adj = scratch;
    for (int d = 0; d < DIGITS; d++) begin
      if (scratch_adj[d*4 +: 4] >= 4'd5)
        scratch_adj[d*4 +: 4] = scratch_adj[d*4 +: 4] + 4'd3;
    end
    scratch_next = {scratch_adj[BCD_W-2:0], bin[WIDTH]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum      <= '0;
      cout     <= 1'b0;
      bin      <= '0;
      scratch  <= '0;
      step_cnt <= '0;
      disp_bcd <= '0;
      done     <= 1'b0;
    end else begin
      done <= finish;
      if (accept) begin
        {cout, sum} <= total;
        bin         <= total;
        scratch     <= '0;
        step_cnt    <= '0;
      end else if (state == CONVERT) begin
        if (finish) begin
          disp_bcd <= scratch;
        end else begin
          scratch  <= scratch_next;
          bin      <= bin << 1;
          step_cnt <= step_cnt + STEP_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt  <= '0;
      digit_idx <= '0;
    end else if (scan_cnt == CNT_W'(REFRESH_DIV - 1)) begin
      scan_cnt  <= '0;
      digit_idx <= (digit_idx == IDX_W'(DIGITS - 1)) ? '0 : digit_idx + IDX_W'(1);
    end else begin
      scan_cnt <= scan_cnt + CNT_W'(1);
    end
  end

`ifdef ACCUM_SEG_BLANK_LEADING_EN
  always_comb begin
    logic seen;
    seen       = 1'b0;
    lead_blank = '0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      if (disp_bcd[i*4 +: 4] != 4'd0) seen = 1'b1;
      lead_blank[i] = !seen;
    end
  end
`else
  assign lead_blank = '0;
`endif

  // A blanked digit is fed to the decoder as a non-decimal nibble.
  assign nib_sel = lead_blank[digit_idx] ? 4'hF : disp_bcd[digit_idx*4 +: 4];

  bcd_to_seg u_bcd_to_seg (
    .nib (nib_sel),
    .seg (seg)
  );

  assign an = ~(DIGITS'(1) << digit_idx);
  assign dp = 1'b1;

endmodule

// File: tb/tb_accum_seg_driver.sv
// Directed bench for accum_seg_driver with WIDTH=8, DIGITS=3, REFRESH_DIV=4.
module tb_accum_seg_driver;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] BL = 7'b1111111;
`ifdef ACCUM_SEG_BLANK_LEADING_EN
  localparam logic [6:0] LZ = BL;
`else
  localparam logic [6:0] LZ = S0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       cin = 1'b0;
  logic       busy, done, cout, dp;
  logic [7:0] sum;
  logic [6:0] seg;
  logic [2:0] an;

  int n_cmp = 0;
  int n_bad = 0;

  accum_seg_driver #(.WIDTH(8), .DIGITS(3), .REFRESH_DIV(4)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout),
    .seg(seg), .an(an), .dp(dp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered at a negedge; returns at the negedge where done is high.
  task automatic add_seq(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                         input logic [8:0] exp_total, input bit poke);
    a = ia; b = ib; cin = ic; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (poke && c == 4) begin
        a = 8'd0; b = 8'd0; cin = 1'b0; start = 1'b1;
      end else if (poke && c == 5) begin
        start = 1'b0;
      end
      if (c < 10) begin
        chk("done_early", done, 0);
        chk("busy_mid", busy, 1);
      end else begin
        chk("done_pulse", done, 1);
        chk("busy_drop", busy, 0);
        chk("sum_cout", {cout, sum}, exp_total);
      end
    end
    start = 1'b0;
  endtask

  task automatic check_digit(input int idx, input logic [6:0] exp_seg, input string tag);
    logic [2:0] want;
    int i;
    want = ~(3'b001 << idx);
    i = 0;
    while (an !== want && i < 20) begin
      @(negedge clk);
      i++;
    end
    chk({tag, "_an"}, an, want);
    chk(tag, seg, exp_seg);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", {cout, sum}, 0);
    chk("rst_an", an, 3'b110);
    chk("rst_seg", seg, S0);
    chk("rst_dp", dp, 1);

    rst = 1'b0;
    #1;
    chk("scan_k0", an, 3'b110);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      case ((k / 4) % 3)
        0: chk("scan_seq", an, 3'b110);
        1: chk("scan_seq", an, 3'b101);
        default: chk("scan_seq", an, 3'b011);
      endcase
      chk("idle_done", done, 0);
    end

    @(negedge clk);
    add_seq(8'd200, 8'd100, 1'b1, 9'd301, 1'b0);
    check_digit(0, S1, "d301_0");
    check_digit(1, S0, "d301_1");
    check_digit(2, S3, "d301_2");

    @(negedge clk);
    add_seq(8'd255, 8'd255, 1'b1, 9'd511, 1'b1);
    @(negedge clk);
    chk("ignored_start_done", done, 0);
    chk("ignored_start_busy", busy, 0);
    chk("ignored_start_sum", {cout, sum}, 9'd511);
    check_digit(0, S1, "d511_0");
    check_digit(1, S1, "d511_1");
    check_digit(2, S5, "d511_2");

    // Back-to-back: second start issued in the done cycle of the first.
    @(negedge clk);
    add_seq(8'd1, 8'd1, 1'b0, 9'd2, 1'b0);
    add_seq(8'd7, 8'd0, 1'b0, 9'd7, 1'b0);
    check_digit(0, S7, "d7_0");
    check_digit(1, LZ, "d7_1");
    check_digit(2, LZ, "d7_2");

    @(negedge clk);
    a = 8'd100; b = 8'd23; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_sum", {cout, sum}, 0);
    chk("mid_rst_an", an, 3'b110);
    chk("mid_rst_seg", seg, S0);
    chk("mid_rst_dp", dp, 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      chk("post_rst_done", done, 0);
      chk("post_rst_busy", busy, 0);
    end
    check_digit(0, S0, "drst_0");
    check_digit(1, LZ, "drst_1");
    check_digit(2, LZ, "drst_2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
